cga_mic_stack_ctl: RTL
======================

Name: cga_mic_stack_ctl

Overview:
Sequencer for the 4-deep microprogram return-address stack, which is built from replicated stack bit slices sharing one SR44-based shift column. It arbitrates call, return, replace and clear requests from the microsequencer and drives the shared slice select lines (S3/S4 decodes, LOAD). It tracks stack occupancy, reports full and empty, and raises sticky overflow and underflow errors.

Parameters:
DEPTH, 4, number of stack entries per bit slice; the occupancy counter is clog2(DEPTH+1) bits wide.
WRAP_ON_FULL, 0, 0 = a push when full is rejected (NAK, OVF set); 1 = the push is accepted, the bottom entry is lost, DEPTH_CNT stays at DEPTH and OVF is still set.

Ports:
CLK  input  1  single system clock; all state updates on the rising edge.
RST  input  1  reset, synchronous to CLK and active-high.
CLR  input  1  empty the stack by resetting the occupancy count only; slice contents are left as they are.
PUSH  input  1  call request: shift the stack down and load STIN into the top entry.
POP  input  1  return request: shift the stack up.
REPL  input  1  replace request: overwrite the top entry, depth unchanged.
S3  output  1  slice mode bit 0.
S3N  output  1  inverse of S3.
S4NS3N  output  1  equals ~S4 & ~S3 (hold decode).
S4S3N  output  1  equals S4 & ~S3 (pop decode).
LOAD  output  1  parallel-load strobe to the SR44 column.
ACK  output  1  one-cycle pulse: the request issued in the previous cycle was accepted.
NAK  output  1  one-cycle pulse: the request issued in the previous cycle was rejected.
DEPTH_CNT  output  clog2(DEPTH+1)  number of valid entries.
EMPTY  output  1  DEPTH_CNT == 0.
FULL  output  1  DEPTH_CNT == DEPTH.
OVF  output  1  sticky overflow flag.
UNF  output  1  sticky underflow flag.

Behaviour:
- Reset (RST=1 at a rising edge):
  - Operation register is set to HOLD, so S3=0, S3N=1, S4NS3N=1, S4S3N=0, LOAD=0.
  - ACK=NAK=0, DEPTH_CNT=0, EMPTY=1, FULL=0, OVF=UNF=0.
  - Reset wins over every request in the same cycle.
- Operation codes, {S4,S3}: HOLD=00, PUSH=01, POP=10, REPL=11.
  - LOAD=1 only for PUSH and REPL.
  - All select outputs are registered: a request sampled at edge N drives the selects for cycle N to N+1. Latency is 1 cycle.
- Priority, evaluated each edge:
  - CLR > (PUSH & POP) > REPL > PUSH > POP.
  - PUSH & POP together are treated as REPL, i.e. a tail call.
  - CLR: issue HOLD, set DEPTH_CNT to 0, pulse ACK; OVF and UNF are not cleared.
  - Only RST clears OVF and UNF.
- Acceptance and rejection:
  - PUSH when not FULL: issue PUSH, DEPTH_CNT+1, ACK.
  - PUSH when FULL and WRAP_ON_FULL=0: issue HOLD, pulse NAK, set OVF.
  - PUSH when FULL and WRAP_ON_FULL=1: issue PUSH, DEPTH_CNT unchanged, ACK, set OVF.
  - POP when not EMPTY: issue POP, DEPTH_CNT-1, ACK.
  - POP when EMPTY: issue HOLD, pulse NAK, set UNF. The slices are never shifted in this case.
  - REPL (or PUSH & POP) when not EMPTY: issue REPL, DEPTH_CNT unchanged, ACK.
  - REPL when EMPTY: issue PUSH, DEPTH_CNT becomes 1, ACK.
  - No request: issue HOLD, ACK=NAK=0.
- Flags and counter:
  - ACK and NAK are mutually exclusive and last exactly one cycle.
  - EMPTY and FULL are decoded from the registered DEPTH_CNT, so they are valid in the cycle after the update.
  - DEPTH_CNT never exceeds DEPTH and never wraps below 0.
- Back-to-back requests are allowed every cycle; there is no busy state.
- Asserting RST in the middle of a sequence discards any pending operation. The next cycle drives HOLD.

Test Plan:
- Reset: hold RST for 2 cycles with PUSH=1 -> selects at HOLD (S4NS3N=1), DEPTH_CNT=0, EMPTY=1, no ACK.
- Fill: 4 consecutive PUSH cycles -> each following cycle has S3=1, LOAD=1, ACK=1; DEPTH_CNT goes 1,2,3,4; FULL=1 after the 4th.
- Overflow, WRAP_ON_FULL=0: a 5th PUSH -> NAK=1, HOLD, DEPTH_CNT=4, OVF=1 and remains 1 through later pops.
- Overflow, WRAP_ON_FULL=1: a 5th PUSH -> ACK=1, S3=1, LOAD=1, DEPTH_CNT=4, OVF=1.
- Drain and underflow: 4 POP cycles -> S4S3N=1 each cycle, DEPTH_CNT goes 3,2,1,0; a 5th POP -> NAK, HOLD, UNF=1.
- Priority: at depth 2 assert PUSH+POP together -> REPL (S4=S3=1, LOAD=1), DEPTH_CNT=2. Then CLR+PUSH together -> HOLD, DEPTH_CNT=0, ACK=1.

Source files
------------

// File: rtl/cga_mic_stack_ctl_if.sv
// Request/status bundle between the microsequencer and the return-address
// stack sequencer: request lines in, registered slice selects and flags out.
interface cga_mic_stack_ctl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          CLR;
  logic          PUSH;
  logic          POP;
  logic          REPL;
  logic          S3;
  logic          S3N;
  logic          S4NS3N;
  logic          S4S3N;
  logic          LOAD;
  logic          ACK;
  logic          NAK;
  logic [CW-1:0] DEPTH_CNT;
  logic          EMPTY;
  logic          FULL;
  logic          OVF;
  logic          UNF;

  modport master (
    output CLR, PUSH, POP, REPL,
    input  S3, S3N, S4NS3N, S4S3N, LOAD, ACK, NAK, DEPTH_CNT, EMPTY, FULL, OVF, UNF
  );

  modport slave (
    input  CLR, PUSH, POP, REPL,
    output S3, S3N, S4NS3N, S4S3N, LOAD, ACK, NAK, DEPTH_CNT, EMPTY, FULL, OVF, UNF
  );
endinterface

// File: rtl/cga_mic_stack_ctl.sv
// Sequencer for the microprogram return-address stack: arbitrates call/return/
// replace/clear, drives the shared SR44 slice selects and tracks occupancy.
module cga_mic_stack_ctl #(
  parameter int DEPTH        = 4,
  parameter bit WRAP_ON_FULL = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  cga_mic_stack_ctl_if.slave bus
);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  // Encoding is the {S4,S3} slice mode presented to every bit slice.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  op_e           op_q, op_d;
  logic          ack_q, ack_d;
  logic          nak_q, nak_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          empty, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q  <= OP_HOLD;
      ack_q <= 1'b0;
      nak_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      ack_q <= ack_d;
      nak_q <= nak_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_comb begin
    op_d  = OP_HOLD;
    ack_d = 1'b0;
    nak_d = 1'b0;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.CLR) begin
      // Only the occupancy is reset; slice contents and sticky errors persist.
      cnt_d = '0;
      ack_d = 1'b1;
    end else if (bus.REPL || (bus.PUSH && bus.POP)) begin
      ack_d = 1'b1;
      if (empty) begin
        op_d  = OP_PUSH;
        cnt_d = ONE_CNT;
      end else begin
        op_d  = OP_REPL;
      end
    end else if (bus.PUSH) begin
      if (!full) begin
        op_d  = OP_PUSH;
        cnt_d = cnt_q + ONE_CNT;
        ack_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (WRAP_ON_FULL) begin
          op_d  = OP_PUSH;
          ack_d = 1'b1;
        end else begin
          nak_d = 1'b1;
        end
      end
    end else if (bus.POP) begin
      if (!empty) begin
        op_d  = OP_POP;
        cnt_d = cnt_q - ONE_CNT;
        ack_d = 1'b1;
      end else begin
        nak_d = 1'b1;
        unf_d = 1'b1;
      end
    end
  end

  assign bus.S3        = op_q[0];
  assign bus.S3N       = ~op_q[0];
  assign bus.S4NS3N    = ~op_q[1] & ~op_q[0];
  assign bus.S4S3N     = op_q[1] & ~op_q[0];
  assign bus.LOAD      = op_q[0];
  assign bus.ACK       = ack_q;
  assign bus.NAK       = nak_q;
  assign bus.DEPTH_CNT = cnt_q;
  assign bus.EMPTY     = empty;
  assign bus.FULL      = full;
  assign bus.OVF       = ovf_q;
  assign bus.UNF       = unf_q;
endmodule
